// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: command opcodes, FSM states, run modes.
package counter_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned LOOP_CNT_W    = 8;

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'b00,
    OP_LOAD     = 2'b01,
    OP_RUN_ONCE = 2'b10,
    OP_RUN_LOOP = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  typedef enum logic {
    MODE_ONCE = 1'b0,
    MODE_LOOP = 1'b1
  } mode_e;

endpackage

// File: rtl/counter_seq_if.sv
// Command channel (valid/ready + opcode/data) between host and counter sequencer.
interface counter_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/counter_seq_reg.sv
// Counter datapath register with complementary output; priority clr > ld > en.
module counter_seq_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q;
    if (clr)     q_next = '0;
    else if (ld) q_next = d;
    else if (en) q_next = q + WIDTH'(1);
  end

  // qbar is kept as its own register so both outputs come straight from flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      qbar <= '1;
    end else begin
      q    <= q_next;
      qbar <= ~q_next;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a WIDTH-bit up-counter with one-shot/loop runs,
// pause and stop. Optional LOOP terminal-event counter: COUNTER_SEQ_LOOP_CNT_EN.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_seq_if.slave          cmd,
  input  logic                  pause,
  input  logic                  stop,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar,
  output logic                  busy,
`ifdef COUNTER_SEQ_LOOP_CNT_EN
  output logic [LOOP_CNT_W-1:0] loop_cnt,
`endif
  output logic                  done
);

  state_e           state, state_next;
  mode_e            mode, mode_next;
  logic [WIDTH-1:0] tc, tc_next;
  logic             done_next;
  logic             reg_clr, reg_ld, reg_en;
  cmd_op_e          op;

  assign op = cmd_op_e'(cmd.cmd_op);

  counter_seq_reg #(.WIDTH(WIDTH)) u_reg (
    .clk  (clk),
    .rst  (rst),
    .clr  (reg_clr),
    .ld   (reg_ld),
    .en   (reg_en),
    .d    (cmd.cmd_data),
    .q    (q),
    .qbar (qbar)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      mode          <= MODE_ONCE;
      tc            <= '1;
      done          <= 1'b0;
      busy          <= 1'b0;
      cmd.cmd_ready <= 1'b1;
    end else begin
      state         <= state_next;
      mode          <= mode_next;
      tc            <= tc_next;
      done          <= done_next;
      busy          <= (state_next != ST_IDLE);
      cmd.cmd_ready <= (state_next == ST_IDLE);
    end
  end

  // Next state and datapath controls; stop > pause > terminal count > increment
  always_comb begin
    state_next = state;
    mode_next  = mode;
    tc_next    = tc;
    done_next  = 1'b0;
    reg_clr    = 1'b0;
    reg_ld     = 1'b0;
    reg_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          case (op)
            OP_CLEAR: reg_clr = 1'b1;
            OP_LOAD:  reg_ld  = 1'b1;
            OP_RUN_ONCE, OP_RUN_LOOP: begin
              tc_next    = cmd.cmd_data;
              mode_next  = (op == OP_RUN_LOOP) ? MODE_LOOP : MODE_ONCE;
              state_next = ST_RUN;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (pause) begin
          state_next = ST_PAUSE;
        end else if (q == tc) begin
          done_next = 1'b1;
          if (mode == MODE_LOOP) reg_clr    = 1'b1;
          else                   state_next = ST_IDLE;
        end else begin
          reg_en = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop)        state_next = ST_IDLE;
        else if (!pause) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef COUNTER_SEQ_LOOP_CNT_EN
  logic loop_evt, loop_clr;

  assign loop_evt = done_next && (mode == MODE_LOOP);
  assign loop_clr = (state == ST_IDLE) && cmd.cmd_valid && (op == OP_CLEAR);

  // Saturating count of LOOP-mode terminal events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_cnt <= '0;
    end else if (loop_clr) begin
      loop_cnt <= '0;
    end else if (loop_evt && (loop_cnt != '1)) begin
      loop_cnt <= loop_cnt + LOOP_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed scenarios plus random commands,
// expectations from a behavioural model, checked by an independent monitor.
module tb_counter_sequencer;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         busy;
    logic         ready;
    logic         done;
    logic [7:0]   lc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pause = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] q, qbar;
  logic         busy, done;
  logic [7:0]   loop_cnt_obs;

  counter_seq_if #(.WIDTH(W)) cif ();

`ifdef COUNTER_SEQ_LOOP_CNT_EN
  logic [7:0] loop_cnt;
  assign loop_cnt_obs = loop_cnt;
`else
  assign loop_cnt_obs = 8'd0;
`endif

  counter_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (cif),
    .pause (pause),
    .stop  (stop),
    .q     (q),
    .qbar  (qbar),
    .busy  (busy),
`ifdef COUNTER_SEQ_LOOP_CNT_EN
    .loop_cnt (loop_cnt),
`endif
    .done  (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  // Reference model: counter value, terminal count, and whether a run is active/paused
  int m_q, m_tc, m_lc;
  bit m_running, m_paused, m_loop;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t snapshot(input bit d);
    exp_t e;
    e.q     = W'(m_q);
    e.qbar  = W'(~m_q);
    e.busy  = m_running;
    e.ready = !m_running;
    e.done  = d;
`ifdef COUNTER_SEQ_LOOP_CNT_EN
    e.lc    = 8'(m_lc);
`else
    e.lc    = 8'd0;
`endif
    return e;
  endfunction

  function automatic bit model_step(input bit v, input int op, input int d, input bit p, input bit s);
    bit dn = 0;
    if (!m_running) begin
      if (v) begin
        if (op == 0) begin m_q = 0; m_lc = 0; end
        else if (op == 1) m_q = d;
        else begin
          m_tc = d; m_loop = (op == 3); m_running = 1; m_paused = 0;
        end
      end
    end else if (s) begin
      m_running = 0; m_paused = 0;
    end else if (m_paused) begin
      if (!p) m_paused = 0;
    end else if (p) begin
      m_paused = 1;
    end else if (m_q == m_tc) begin
      dn = 1;
      if (m_loop) begin
        m_q = 0;
        if (m_lc < 255) m_lc++;
      end else m_running = 0;
    end else begin
      m_q = (m_q + 1) % (1 << W);
    end
    return dn;
  endfunction

  task automatic step(input bit v, input int op, input int d, input bit p, input bit s);
    bit dn;
    @(negedge clk);
    cif.cmd_valid = v;
    cif.cmd_op    = 2'(op);
    cif.cmd_data  = W'(d);
    pause = p;
    stop  = s;
    dn = model_step(v, op, d, p, s);
    sb.push_back(snapshot(dn));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic run_until(input int target);
    int n = 0;
    while (m_q != target && n < 40) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    if (m_q != target) chk("run_until_timeout", m_q, target);
  endtask

  // Async reset asserted between edges; outputs must change before any clock edge
  task automatic do_reset();
    @(negedge clk);
    cif.cmd_valid = 0; pause = 0; stop = 0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q", q, 0);
    chk("async_rst_qbar", qbar, (1 << W) - 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", cif.cmd_ready, 1);
    chk("async_rst_done", done, 0);
    chk("async_rst_loop_cnt", loop_cnt_obs, 0);
    m_q = 0; m_tc = (1 << W) - 1; m_lc = 0;
    m_running = 0; m_paused = 0; m_loop = 0;
    sb.push_back(snapshot(0));
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("qbar", qbar, e.qbar);
        chk("busy", busy, e.busy);
        chk("cmd_ready", cif.cmd_ready, e.ready);
        chk("done", done, e.done);
        chk("loop_cnt", loop_cnt_obs, e.lc);
      end
    end
  end

  initial begin
    int op, r;
    cif.cmd_valid = 0; cif.cmd_op = 0; cif.cmd_data = 0;
    do_reset();

    // LOAD 3, one-shot to 7
    step(1, 1, 3, 0, 0);
    step(1, 2, 7, 0, 0);
    idle(7);

    // CLEAR, loop with tc=2 for 9 cycles, then stop
    step(1, 0, 0, 0, 0);
    step(1, 3, 2, 0, 0);
    idle(9);
    step(0, 0, 0, 0, 1);
    idle(2);

    // One-shot to A with a 3-cycle pause at 4
    step(1, 0, 0, 0, 0);
    step(1, 2, 10, 0, 0);
    run_until(4);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    idle(10);

    // Rerun, stop at 6
    step(1, 0, 0, 0, 0);
    step(1, 2, 10, 0, 0);
    run_until(6);
    step(0, 0, 0, 0, 1);
    idle(3);

    // Wrap from E to tc=1; commands offered while running are ignored
    step(1, 1, 14, 0, 0);
    step(1, 2, 1, 0, 0);
    step(1, 1, 9, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(4);

    // Start with q==tc: terminal on first run edge
    step(1, 1, 5, 0, 0);
    step(1, 2, 5, 0, 0);
    idle(2);

    // Async reset mid-run at q=5
    step(1, 0, 0, 0, 0);
    step(1, 2, 12, 0, 0);
    run_until(5);
    do_reset();

    // Randomized commands, pauses, stops and occasional resets
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 399);
      op = $urandom_range(0, 3);
      if (r == 0) do_reset();
      else step($urandom_range(0, 3) != 0, op, $urandom_range(0, (1 << W) - 1),
                $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    end
    idle(3);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
